// File: rtl/rr_write_port_arbiter.sv
// rtl/rr_write_port_arbiter.sv - round-robin arbiter for a shared register-file write port
//
// Shares a single register-file write port among NUM_REQ requesters. Arbitration is
// round robin. An owner keeps the port for at most MAX_HOLD back-to-back writes, and
// is then handed off to the next requester without an idle cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   req      per-requester write-pending flags
//   wdata    packed write data, requester i at [i*DATA_BITS +: DATA_BITS]
//   waddr    packed write addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//   gnt      registered one-hot grant (zero when idle)
//   mux_sel  registered binary index of the current owner
//   wr_en    write strobe (owner granted and still requesting)
//   wr_addr  destination register of the owner
//   wr_data  write data of the owner
//   busy     high while a requester owns the port
module rr_write_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4,
  parameter int MAX_HOLD  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   wdata,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   waddr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [$clog2(NUM_REQ)-1:0]     mux_sel,
  output logic                           wr_en,
  output logic [ADDR_BITS-1:0]           wr_addr,
  output logic [DATA_BITS-1:0]           wr_data,
  output logic                           busy
);

  localparam int SEL_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state;
  logic [SEL_W-1:0]    last_owner;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [SEL_W-1:0]    search_start;
  logic [NUM_REQ-1:0]  cand;
  logic                win_valid;
  logic [SEL_W-1:0]    win_idx;
  logic                owner_req;
  logic                hold_done;

  assign owner_req = req[mux_sel];
  assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // While owned, the search starts just past the current owner and excludes it, so a
  // release hands the port to someone else when possible. When idle, it starts just
  // past the last owner.
  always_comb begin
    search_start = last_owner;
    cand         = req;
    if (state == OWNED) begin
      search_start = mux_sel;
      cand         = req & ~(NUM_REQ'(1) << mux_sel);
    end
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(search_start) + k) % NUM_REQ;
      if (!win_valid && cand[idx]) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      mux_sel    <= '0;
      hold_cnt   <= '0;
      last_owner <= SEL_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= OWNED;
            gnt      <= NUM_REQ'(1) << win_idx;
            mux_sel  <= win_idx;
            hold_cnt <= '0;
          end
        end
        OWNED: begin
          if (!owner_req || hold_done) begin
            last_owner <= mux_sel;
            hold_cnt   <= '0;
            if (win_valid) begin
              gnt     <= NUM_REQ'(1) << win_idx;
              mux_sel <= win_idx;
            end else if (!owner_req) begin
              state <= IDLE;
              gnt   <= '0;
            end
            // Otherwise the hold expired with nobody else waiting: the owner keeps
            // the grant with a fresh count.
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign wr_en   = |(gnt & req);
  assign wr_addr = waddr[int'(mux_sel)*ADDR_BITS +: ADDR_BITS];
  assign wr_data = wdata[int'(mux_sel)*DATA_BITS +: DATA_BITS];
  assign busy    = (state == OWNED);

endmodule

// File: tb/tb_rr_write_port_arbiter.sv
// tb/tb_rr_write_port_arbiter.sv - directed self-checking bench for rr_write_port_arbiter
module tb_rr_write_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [15:0] waddr;
  logic [3:0]  gnt;
  logic [1:0]  mux_sel;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_addr [4] = '{4'hA, 4'h5, 4'h6, 4'h7};
  logic [7:0] exp_data [4] = '{8'h5C, 8'h11, 8'h22, 8'h33};

  rr_write_port_arbiter #(
    .NUM_REQ(4), .DATA_BITS(8), .ADDR_BITS(4), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .waddr(waddr),
    .gnt(gnt), .mux_sel(mux_sel), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    waddr = {4'h7, 4'h6, 4'h5, 4'hA};
    wdata = {8'h33, 8'h22, 8'h11, 8'h5C};

    // Reset held 3 cycles with every requester pending.
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", gnt, 4'b0000);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    reset = 1'b0;

    // Fairness: owners 0,1,2,3,0,1,2 with 4 writes each; reset lands on owner 2's 2nd write.
    for (int i = 0; i < 26; i++) begin
      tick();
      check("rr_gnt", gnt, 4'b0001 << ((i / 4) % 4));
      check("rr_sel", mux_sel, (i / 4) % 4);
      check("rr_wr_en", wr_en, 1'b1);
      check("rr_busy", busy, 1'b1);
      check("rr_addr", wr_addr, exp_addr[(i / 4) % 4]);
      check("rr_data", wr_data, exp_data[(i / 4) % 4]);
    end

    // Mid-op reset during owner 2's 2nd write.
    reset = 1'b1;
    tick();
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_wr_en", wr_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check("midrst_regnt", gnt, 4'b0001);

    // Single requester 2: regranted with no gap after each 4 writes.
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    check("idle_gnt", gnt, 4'b0000);
    check("idle_busy", busy, 1'b0);
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("single_gnt", gnt, 4'b0100);
      check("single_sel", mux_sel, 2'd2);
      check("single_wr_en", wr_en, 1'b1);
    end

    // Early drop: owner 1 drops after 2 writes while requester 3 waits.
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
    req   = 4'b0010;
    tick();
    check("drop_gnt1", gnt, 4'b0010);
    check("drop_wr1", wr_en, 1'b1);
    req = 4'b1010;
    tick();
    check("drop_gnt2", gnt, 4'b0010);
    check("drop_wr2", wr_en, 1'b1);
    req = 4'b1000;
    #1;
    check("drop_dead", wr_en, 1'b0);
    tick();
    check("drop_gnt3", gnt, 4'b1000);
    check("drop_sel3", mux_sel, 2'd3);
    check("drop_wr3", wr_en, 1'b1);
    check("drop_addr3", wr_addr, 4'h7);
    check("drop_data3", wr_data, 8'h33);

    // Data path from requester 0.
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
    req   = 4'b0001;
    tick();
    check("dp_gnt", gnt, 4'b0001);
    check("dp_sel", mux_sel, 2'd0);
    check("dp_wr_en", wr_en, 1'b1);
    check("dp_addr", wr_addr, 4'hA);
    check("dp_data", wr_data, 8'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
